// File: rtl/mem_arb_pkg.sv
// Shared types and default bus widths for the two-port round-robin memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  typedef enum logic [1:0] {IDLE, RD_OWN, WR_OWN, DRAIN} arb_state_t;
  typedef enum logic {PORT_RD, PORT_WR} port_t;

endpackage

// File: rtl/mem_arb_outst_ctr.sv
// In-flight read counter: up on accepted read, down on returned data, sticky flag
// when data comes back with nothing outstanding.
module mem_arb_outst_ctr #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Next count; a return at zero holds the count at zero and raises the flag
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({inc, dec})
      2'b10: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        else                  cnt_d = cnt_q;
      end
      2'b01: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      2'b11: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter and flag registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt           = cnt_q;
  assign err_underflow = err_q;

endmodule

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter sharing one memory bus between a read-only and a write-only
// port, with bounded bursts and a drain of in-flight reads before handing to the writer.
module mem_rr_arb #(
  parameter int ADDR_W    = mem_arb_pkg::ADDR_W,
  parameter int DATA_W    = mem_arb_pkg::DATA_W,
  parameter int BE_W      = mem_arb_pkg::BE_W,
  parameter int MAX_BURST = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                             clock,
  input  logic                             reset_n,
  output logic [ADDR_W-1:0]                mem_address,
  output logic [BE_W-1:0]                  mem_byteenable,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [DATA_W-1:0]                mem_writedata,
  input  logic [DATA_W-1:0]                mem_readdata,
  input  logic                             mem_readdataready,
  input  logic                             mem_waitrequest,
  input  logic [ADDR_W-1:0]                rd_address,
  input  logic [BE_W-1:0]                  rd_byteenable,
  input  logic                             rd_read,
  output logic [DATA_W-1:0]                rd_readdata,
  output logic                             rd_readdataready,
  output logic                             rd_waitrequest,
  input  logic [ADDR_W-1:0]                wr_address,
  input  logic [BE_W-1:0]                  wr_byteenable,
  input  logic                             wr_write,
  input  logic [DATA_W-1:0]                wr_writedata,
  output logic                             wr_waitrequest,
  output logic                             grant_rd,
  output logic                             grant_wr,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt,
  output logic                             err_underflow
);
  import mem_arb_pkg::*;

  localparam int CNT_W   = $clog2(MAX_OUTST + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]   OUTST_MAX = CNT_W'(MAX_OUTST);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_t         state_q, state_d;
  port_t              last_served_q, last_served_d;
  logic               grant_rd_q, grant_rd_d;
  logic               grant_wr_q, grant_wr_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d, burst_next;
  logic               outst_full, rd_accept, wr_accept;

  assign outst_full = (outst_cnt == OUTST_MAX);
  assign rd_accept  = grant_rd_q & rd_read & ~mem_waitrequest & ~outst_full;
  assign wr_accept  = grant_wr_q & wr_write & ~mem_waitrequest;

  mem_arb_outst_ctr #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_outst_ctr (
    .clock         (clock),
    .reset_n       (reset_n),
    .inc           (rd_accept),
    .dec           (mem_readdataready),
    .cnt           (outst_cnt),
    .err_underflow (err_underflow)
  );

  // Bus steering from the registered grant; idle bus is driven to zero
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (grant_rd_q) begin
      mem_address    = rd_address;
      mem_byteenable = rd_byteenable;
    end else if (grant_wr_q) begin
      mem_address    = wr_address;
      mem_byteenable = wr_byteenable;
      mem_writedata  = wr_writedata;
    end else begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
    end
  end

  assign mem_read         = grant_rd_q & rd_read & ~outst_full;
  assign mem_write        = grant_wr_q & wr_write;
  assign rd_waitrequest   = ~grant_rd_q | mem_waitrequest | outst_full;
  assign wr_waitrequest   = ~grant_wr_q | mem_waitrequest;
  assign rd_readdata      = mem_readdata;
  assign rd_readdataready = mem_readdataready;
  assign grant_rd         = grant_rd_q;
  assign grant_wr         = grant_wr_q;

  // Ownership FSM; a hand-over only happens once the owner has no stalled command
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    burst_cnt_d   = burst_cnt_q;
    burst_next    = burst_cnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (rd_read && wr_write) begin
          if (last_served_q == PORT_WR) state_d = RD_OWN;
          else                          state_d = WR_OWN;
        end else if (rd_read) begin
          state_d = RD_OWN;
        end else if (wr_write) begin
          state_d = WR_OWN;
        end else begin
          state_d = IDLE;
        end
      end
      RD_OWN: begin
        if (rd_accept && (burst_cnt_q != BURST_MAX)) burst_next = burst_cnt_q + BURST_W'(1);
        else                                         burst_next = burst_cnt_q;
        burst_cnt_d = burst_next;
        if (wr_write && (!rd_read || (rd_accept && (burst_next == BURST_MAX)))) begin
          burst_cnt_d   = '0;
          last_served_d = PORT_RD;
          if ((outst_cnt != '0) || rd_accept) state_d = DRAIN;
          else                                state_d = WR_OWN;
        end else if (!rd_read && !wr_write) begin
          burst_cnt_d   = '0;
          last_served_d = PORT_RD;
          state_d       = IDLE;
        end else begin
          state_d = RD_OWN;
        end
      end
      WR_OWN: begin
        if (wr_accept && (burst_cnt_q != BURST_MAX)) burst_next = burst_cnt_q + BURST_W'(1);
        else                                         burst_next = burst_cnt_q;
        burst_cnt_d = burst_next;
        if (rd_read && (!wr_write || (wr_accept && (burst_next == BURST_MAX)))) begin
          burst_cnt_d   = '0;
          last_served_d = PORT_WR;
          state_d       = RD_OWN;
        end else if (!wr_write && !rd_read) begin
          burst_cnt_d   = '0;
          last_served_d = PORT_WR;
          state_d       = IDLE;
        end else begin
          state_d = WR_OWN;
        end
      end
      DRAIN: begin
        burst_cnt_d = '0;
        if (outst_cnt == '0) begin
          if (wr_write) state_d = WR_OWN;
          else          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        burst_cnt_d = '0;
        state_d     = IDLE;
      end
    endcase
    grant_rd_d = (state_d == RD_OWN);
    grant_wr_d = (state_d == WR_OWN);
  end

  // Arbiter state registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_served_q <= PORT_WR;
      grant_rd_q    <= 1'b0;
      grant_wr_q    <= 1'b0;
      burst_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      grant_rd_q    <= grant_rd_d;
      grant_wr_q    <= grant_wr_d;
      burst_cnt_q   <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_rr_arb.sv
// Directed bench for mem_rr_arb: each step drives inputs just after the rising edge
// and checks hand-computed outputs mid-cycle; a latency pipe returns read data.
module tb_mem_rr_arb;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [19:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic        mem_read, mem_write;
  logic [15:0] mem_writedata, mem_readdata;
  logic        mem_readdataready, mem_waitrequest;
  logic [19:0] rd_address, wr_address;
  logic [1:0]  rd_byteenable, wr_byteenable;
  logic        rd_read, wr_write;
  logic [15:0] rd_readdata, wr_writedata;
  logic        rd_readdataready, rd_waitrequest, wr_waitrequest;
  logic        grant_rd, grant_wr, err_underflow;
  logic [2:0]  outst_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] pend;
  int          lat;
  int          cyc_n;
  int          exp_outst [16];

  always #5 clock = ~clock;

  mem_rr_arb dut (
    .clock(clock), .reset_n(reset_n),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_readdataready(mem_readdataready),
    .mem_waitrequest(mem_waitrequest),
    .rd_address(rd_address), .rd_byteenable(rd_byteenable), .rd_read(rd_read),
    .rd_readdata(rd_readdata), .rd_readdataready(rd_readdataready),
    .rd_waitrequest(rd_waitrequest),
    .wr_address(wr_address), .wr_byteenable(wr_byteenable), .wr_write(wr_write),
    .wr_writedata(wr_writedata), .wr_waitrequest(wr_waitrequest),
    .grant_rd(grant_rd), .grant_wr(grant_wr),
    .outst_cnt(outst_cnt), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; reads accepted this cycle come back lat cycles later
  task automatic step();
    #1;
    if (mem_read && !mem_waitrequest) pend[lat] = 1'b1;
    @(posedge clock);
    #1;
    pend = pend >> 1;
    mem_readdataready = pend[0];
    cyc_n++;
    mem_readdata = 16'(32'hA000 + cyc_n);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rd_read = 1'b0;
    wr_write = 1'b0;
    mem_waitrequest = 1'b0;
    step();
    step();
    pend = '0;
    mem_readdataready = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset_n = 1'b0; rd_read = 1'b0; wr_write = 1'b0; mem_waitrequest = 1'b0;
    mem_readdata = 16'h0; mem_readdataready = 1'b0;
    rd_address = 20'h0; rd_byteenable = 2'b00; wr_address = 20'h0;
    wr_byteenable = 2'b00; wr_writedata = 16'h0;
    pend = '0; lat = 2; cyc_n = 0;
    exp_outst = '{0, 0, 1, 2, 3, 4, 4, 4, 3, 3, 3, 3, 4, 4, 4, 3};

    // ---- reset state, then tie from reset: 8 reads, drain, 8 writes, back to reads
    do_reset();
    #2;
    chk("rst_grant_rd", 32'(grant_rd), 32'd0);
    chk("rst_grant_wr", 32'(grant_wr), 32'd0);
    chk("rst_outst", 32'(outst_cnt), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_rd_wait", 32'(rd_waitrequest), 32'd1);
    chk("rst_wr_wait", 32'(wr_waitrequest), 32'd1);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_be", 32'(mem_byteenable), 32'd0);
    chk("rst_wdata", 32'(mem_writedata), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));

    rd_read = 1'b1; wr_write = 1'b1;
    rd_address = 20'h00100; rd_byteenable = 2'b11;
    wr_address = 20'h00200; wr_byteenable = 2'b01; wr_writedata = 16'h5A5A;
    #2;
    chk("t1_c0_grant_rd", 32'(grant_rd), 32'd0);
    chk("t1_c0_mem_read", 32'(mem_read), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step();
      rd_address = 20'(32'h100 + i);
      #2;
      chk("t1_rd_grant", 32'(grant_rd), 32'd1);
      chk("t1_rd_mem_read", 32'(mem_read), 32'd1);
      chk("t1_rd_wait", 32'(rd_waitrequest), 32'd0);
      chk("t1_rd_addr", 32'(mem_address), 32'h100 + i);
      chk("t1_rd_be", 32'(mem_byteenable), 32'd3);
      chk("t1_rd_outst", 32'(outst_cnt), (i == 1) ? 32'd0 : (i == 2) ? 32'd1 : 32'd2);
      chk("t1_rd_rdy", 32'(rd_readdataready), 32'(i >= 3));
      chk("t1_rd_data", 32'(rd_readdata), 32'(mem_readdata));
    end
    for (int i = 9; i <= 11; i++) begin
      step();
      #2;
      chk("t1_drain_grant_rd", 32'(grant_rd), 32'd0);
      chk("t1_drain_grant_wr", 32'(grant_wr), 32'd0);
      chk("t1_drain_rd_wait", 32'(rd_waitrequest), 32'd1);
      chk("t1_drain_wr_wait", 32'(wr_waitrequest), 32'd1);
      chk("t1_drain_mem_read", 32'(mem_read), 32'd0);
      chk("t1_drain_mem_write", 32'(mem_write), 32'd0);
      chk("t1_drain_outst", 32'(outst_cnt), 32'(11 - i));
      chk("t1_drain_rdy", 32'(rd_readdataready), 32'(i <= 10));
    end
    for (int i = 12; i <= 19; i++) begin
      step();
      wr_writedata = 16'(32'h5A00 + i);
      #2;
      chk("t1_wr_grant", 32'(grant_wr), 32'd1);
      chk("t1_wr_mem_write", 32'(mem_write), 32'd1);
      chk("t1_wr_mem_read", 32'(mem_read), 32'd0);
      chk("t1_wr_wait", 32'(wr_waitrequest), 32'd0);
      chk("t1_wr_wdata", 32'(mem_writedata), 32'h5A00 + i);
      chk("t1_wr_addr", 32'(mem_address), 32'h200);
      chk("t1_wr_be", 32'(mem_byteenable), 32'd1);
    end
    step();
    #2;
    chk("t1_back_grant_rd", 32'(grant_rd), 32'd1);
    chk("t1_back_grant_wr", 32'(grant_wr), 32'd0);
    chk("t1_back_mem_read", 32'(mem_read), 32'd1);

    // ---- write burst stalled 3 cycles on write 5 while the reader waits
    do_reset();
    lat = 2;
    wr_write = 1'b1; wr_address = 20'h00300; wr_byteenable = 2'b10; wr_writedata = 16'h3000;
    for (int i = 1; i <= 11; i++) begin
      int k;
      k = (i <= 4) ? i : (i <= 8) ? 5 : i - 3;
      step();
      rd_read = (i >= 2);
      mem_waitrequest = (i >= 5 && i <= 7);
      wr_writedata = 16'(32'h3000 + k);
      #2;
      chk("t3_grant_wr", 32'(grant_wr), 32'd1);
      chk("t3_grant_rd", 32'(grant_rd), 32'd0);
      chk("t3_mem_write", 32'(mem_write), 32'd1);
      chk("t3_wr_wait", 32'(wr_waitrequest), 32'(i >= 5 && i <= 7));
      chk("t3_wdata", 32'(mem_writedata), 32'h3000 + k);
      chk("t3_addr", 32'(mem_address), 32'h300);
      if (i == 8)  chk("t3_burst_at_w5", 32'(dut.burst_cnt_q), 32'd4);
      if (i == 11) chk("t3_burst_at_w8", 32'(dut.burst_cnt_q), 32'd7);
    end
    step();
    mem_waitrequest = 1'b0;
    #2;
    chk("t3_sw_grant_rd", 32'(grant_rd), 32'd1);
    chk("t3_sw_grant_wr", 32'(grant_wr), 32'd0);
    chk("t3_sw_mem_read", 32'(mem_read), 32'd1);
    chk("t3_sw_mem_write", 32'(mem_write), 32'd0);

    // ---- read port alone, 6-cycle latency, in-flight limit of 4
    do_reset();
    lat = 6;
    rd_read = 1'b1; rd_address = 20'h00400;
    for (int i = 1; i <= 15; i++) begin
      step();
      #2;
      chk("t2_grant_rd", 32'(grant_rd), 32'd1);
      chk("t2_outst", 32'(outst_cnt), 32'(exp_outst[i]));
      chk("t2_rd_wait", 32'(rd_waitrequest), 32'(exp_outst[i] == 4));
      chk("t2_mem_read", 32'(mem_read), 32'(exp_outst[i] != 4));
    end
    chk("t2_burst_sat", 32'(dut.burst_cnt_q), 32'd8);

    // ---- reader drops after 2 reads with 2 in flight; drain then writer
    do_reset();
    lat = 4;
    rd_read = 1'b1; wr_write = 1'b1;
    rd_address = 20'h00600; wr_address = 20'h00500; wr_writedata = 16'h4444;
    for (int i = 1; i <= 2; i++) begin
      step();
      #2;
      chk("t4_grant_rd", 32'(grant_rd), 32'd1);
      chk("t4_mem_read", 32'(mem_read), 32'd1);
    end
    step();
    rd_read = 1'b0;
    #2;
    chk("t4_c3_grant_rd", 32'(grant_rd), 32'd1);
    chk("t4_c3_outst", 32'(outst_cnt), 32'd2);
    chk("t4_c3_mem_read", 32'(mem_read), 32'd0);
    step();
    #2;
    chk("t4_c4_grant_rd", 32'(grant_rd), 32'd0);
    chk("t4_c4_grant_wr", 32'(grant_wr), 32'd0);
    chk("t4_c4_state", 32'(dut.state_q), 32'(DRAIN));
    chk("t4_c4_wr_wait", 32'(wr_waitrequest), 32'd1);
    chk("t4_c4_outst", 32'(outst_cnt), 32'd2);
    step();
    #2;
    chk("t4_c5_outst", 32'(outst_cnt), 32'd2);
    chk("t4_c5_rdy", 32'(rd_readdataready), 32'd1);
    step();
    #2;
    chk("t4_c6_outst", 32'(outst_cnt), 32'd1);
    step();
    #2;
    chk("t4_c7_outst", 32'(outst_cnt), 32'd0);
    chk("t4_c7_grant_wr", 32'(grant_wr), 32'd0);
    chk("t4_c7_state", 32'(dut.state_q), 32'(DRAIN));
    step();
    #2;
    chk("t4_c8_grant_wr", 32'(grant_wr), 32'd1);
    chk("t4_c8_burst", 32'(dut.burst_cnt_q), 32'd0);
    chk("t4_c8_mem_write", 32'(mem_write), 32'd1);
    chk("t4_c8_wr_wait", 32'(wr_waitrequest), 32'd0);
    chk("t4_c8_wdata", 32'(mem_writedata), 32'h4444);

    // ---- reset mid-burst with 3 reads in flight; late returns flag underflow
    do_reset();
    lat = 6;
    rd_read = 1'b1; rd_address = 20'h00700;
    for (int i = 1; i <= 4; i++) step();
    #2;
    chk("t6_c4_outst", 32'(outst_cnt), 32'd3);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    rd_read = 1'b0;
    #2;
    chk("t6_state", 32'(dut.state_q), 32'(IDLE));
    chk("t6_outst", 32'(outst_cnt), 32'd0);
    chk("t6_grant_rd", 32'(grant_rd), 32'd0);
    chk("t6_rd_wait", 32'(rd_waitrequest), 32'd1);
    chk("t6_wr_wait", 32'(wr_waitrequest), 32'd1);
    chk("t6_mem_read", 32'(mem_read), 32'd0);
    chk("t6_mem_write", 32'(mem_write), 32'd0);
    step();
    step();
    #2;
    chk("t6_c7_rdy", 32'(rd_readdataready), 32'd1);
    chk("t6_c7_err", 32'(err_underflow), 32'd0);
    step();
    #2;
    chk("t6_c8_err", 32'(err_underflow), 32'd1);
    chk("t6_c8_outst", 32'(outst_cnt), 32'd0);

    // ---- spurious return at zero: sticky flag until a reset edge
    do_reset();
    #2;
    chk("t5_err_cleared", 32'(err_underflow), 32'd0);
    mem_readdataready = 1'b1;
    #2;
    chk("t5_rdy_pass", 32'(rd_readdataready), 32'd1);
    chk("t5_c0_outst", 32'(outst_cnt), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      #2;
      chk("t5_err_sticky", 32'(err_underflow), 32'd1);
      chk("t5_outst_zero", 32'(outst_cnt), 32'd0);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #2;
    chk("t5_err_after_rst", 32'(err_underflow), 32'd0);
    chk("t5_outst_after_rst", 32'(outst_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
